// File: rtl/channel_in_pair_packer_pkg.sv
// Shared parameters for the channel-in pair packer: beat width W and FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Shared macros `PICTURE_NUM and `WIDTH_DATA_OUT are given defaults here
// unless the build provides them. Optional feature macro used by the top:
// PAIR_PACK_CNT_EN.

`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif

`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 8
`endif

package channel_in_pair_packer_pkg;

   // One channel-group partial-sum beat.
   localparam int W = `PICTURE_NUM * `WIDTH_DATA_OUT * 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,   // no beat held
      ST_HALF  = 1'b1    // first beat of a pair sits in the hold register
   } pack_state_e;

endpackage

// File: rtl/channel_in_pair_packer_pack_out_reg.sv
// Output register of the pair packer: loads a completed word, holds it until taken.
// Latency: 1 cycle from load to m_valid.
// Backpressure: s_ready low only while a word is held and m_ready is low; drains and reloads in one cycle.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   load, load_data/last/pad      completed word from the packer FSM
//   s_ready                       upstream may hand over a beat this cycle
//   m_valid/m_ready/m_data/m_last/odd_pad   downstream valid/ready word

module pack_out_reg
   import channel_in_pair_packer_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [2*W-1:0] load_data,
   input  logic           load_last,
   input  logic           load_pad,
   output logic           s_ready,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [2*W-1:0] m_data,
   output logic           m_last,
   output logic           odd_pad
);

   logic           valid_q, valid_d;
   logic [2*W-1:0] data_q,  data_d;
   logic           last_q,  last_d;
   logic           pad_q,   pad_d;

   // A load can only arrive while s_ready is high, so it never overwrites
   // a word that has not been taken.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      pad_d   = pad_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         last_d  = load_last;
         pad_d   = load_pad;
      end else if (valid_q && m_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         pad_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         pad_q   <= pad_d;
      end
   end

   assign s_ready = !(valid_q && !m_ready);
   assign m_valid = valid_q;
   assign m_data  = data_q;
   assign m_last  = last_q;
   assign odd_pad = pad_q;

endmodule

// File: rtl/channel_in_pair_packer.sv
// Packs two consecutive channel-group beats into one 2*W word; a lone last beat is zero-padded.
// Latency: 1 cycle from the completing beat to m_valid.
// Backpressure: s_ready = !(m_valid && !m_ready); full throughput of one word per two beats.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   s_valid/s_ready/s_data/s_last      upstream beat stream
//   m_valid/m_ready/m_data/m_last      packed word stream ({first, second})
//   odd_pad                            lower half of m_data is zero padding
//   pair_cnt [15:0]                    words handed downstream (only with PAIR_PACK_CNT_EN)

module channel_in_pair_packer
   import channel_in_pair_packer_pkg::*;
#(
   parameter int COMPUTE_CHANNEL_IN_NUM = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_data,
   input  logic           s_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [2*W-1:0] m_data,
   output logic           m_last,
   output logic           odd_pad
`ifdef PAIR_PACK_CNT_EN
   ,
   output logic [15:0]    pair_cnt
`endif
);

   if (COMPUTE_CHANNEL_IN_NUM != 2) begin : g_bad_cfg
      $error("channel_in_pair_packer supports only COMPUTE_CHANNEL_IN_NUM = 2");
   end

   pack_state_e    state_q, state_d;
   logic [W-1:0]   hold_q,  hold_d;

   logic           accept;
   logic           load;
   logic [2*W-1:0] load_data;
   logic           load_last;
   logic           load_pad;

   assign accept = s_valid && s_ready;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      load      = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      load_pad  = 1'b0;
      if (accept) begin
         case (state_q)
            ST_EMPTY: begin
               if (s_last) begin
                  // Pixel set ended on an odd beat: emit it alone, padded.
                  load      = 1'b1;
                  load_data = {s_data, {W{1'b0}}};
                  load_last = 1'b1;
                  load_pad  = 1'b1;
               end else begin
                  hold_d  = s_data;
                  state_d = ST_HALF;
               end
            end
            ST_HALF: begin
               load      = 1'b1;
               load_data = {hold_q, s_data};
               load_last = s_last;
               load_pad  = 1'b0;
               state_d   = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   pack_out_reg u_pack_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .load_pad  (load_pad),
      .s_ready   (s_ready),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .odd_pad   (odd_pad)
   );

`ifdef PAIR_PACK_CNT_EN
   logic [15:0] pair_cnt_q, pair_cnt_d;

   // 16-bit wrap is the natural rollover.
   always_comb begin
      pair_cnt_d = pair_cnt_q;
      if (m_valid && m_ready) begin
         pair_cnt_d = pair_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_cnt_q <= '0;
      end else begin
         pair_cnt_q <= pair_cnt_d;
      end
   end

   assign pair_cnt = pair_cnt_q;
`endif

endmodule
